auth_session_scheduler: RTL and testbench

Sequences the shared EV–CS authentication engine among up to NUM_REQ requesters (charging-station ports). Arbitrates requests round-robin, performs the timestamp freshness check before committing the engine, launches and watches the engine, and reports a per-request status. It also keeps a per-requester session-token lifetime so that recently authenticated requesters can skip the engine. Sits between the port front-ends and the single authentication datapath instance.

---
 rtl/auth_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/auth_session_scheduler.sv | 178 +++++++++++++++++
 tb/tb_auth_session_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_sched_pkg.sv
// auth_sched_pkg: shared constants and types for the authentication session
// scheduler (status codes, FSM state encoding, timestamp width).
package auth_sched_pkg;

    localparam int TS_W = 64;

    localparam logic [2:0] STS_OK      = 3'd0;
    localparam logic [2:0] STS_CACHED  = 3'd1;
    localparam logic [2:0] STS_STALE   = 3'd2;
    localparam logic [2:0] STS_FAIL    = 3'd3;
    localparam logic [2:0] STS_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_CHECK  = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_REPORT = 3'd5
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among N requesters, searching upward from
// pointer. index is the winner whenever any request is present; the one-hot
// grant is only driven when grant_en is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] pointer,
    input  logic                 grant_en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] index
);

    localparam int IW = $clog2(N);

    int   cand;
    logic found;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(pointer) + i) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = IW'(cand);
            end
        end
        if (found && grant_en) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/auth_session_scheduler.sv
// auth_session_scheduler: sequences the shared EV-CS authentication engine
// among NUM_REQ ports: round-robin grant, timestamp freshness check, engine
// launch with watchdog, per-request completion status and session tokens.
// Build option: `define AUTH_TOKEN_CACHE_EN lets a fresh request with a live
// token complete as CACHED without touching the engine.
module auth_session_scheduler
    import auth_sched_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int ACCEPTABLE_DELAY = 10,
    parameter int ENG_TIMEOUT      = 32,
    parameter int T_VALID          = 60
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*TS_W-1:0]    req_ts,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [TS_W-1:0]            now_ts,
    output logic                       eng_start,
    output logic [$clog2(NUM_REQ)-1:0] eng_id,
    output logic                       eng_abort,
    input  logic                       eng_done,
    input  logic                       eng_ok,
    output logic                       done_valid,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic [2:0]                 done_status,
    output logic [NUM_REQ-1:0]         token_live
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(ENG_TIMEOUT + 1);
    localparam int TOK_W = $clog2(T_VALID + 1);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                id_q, id_d;
    logic [IDX_W-1:0]                ptr_q, ptr_d;
    logic [TS_W-1:0]                 ts_q, ts_d;
    logic [TS_W-1:0]                 now_q, now_d;
    logic [WD_W-1:0]                 wd_q, wd_d;
    logic [2:0]                      status_q, status_d;
    logic [NUM_REQ-1:0][TOK_W-1:0]   tok_q, tok_d;

    logic [NUM_REQ-1:0]              arb_grant;
    logic [IDX_W-1:0]                arb_idx;
    logic [TS_W-1:0]                 delta;
    logic                            stale;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req      (req_valid),
        .pointer  (ptr_q),
        .grant_en (state_q == S_ARB),
        .grant    (arb_grant),
        .index    (arb_idx)
    );

    // Future timestamps wrap to a huge delta, so they fall out as stale too.
    assign now_d = now_q + 64'd1;
    assign delta = now_q - ts_q;
    assign stale = delta > TS_W'(ACCEPTABLE_DELAY);

    // Session FSM: grant, freshness/token check, engine launch and watchdog.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        ts_d     = ts_q;
        wd_d     = wd_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) state_d = S_ARB;
            end
            S_ARB: begin
                if (|req_valid) begin
                    id_d    = arb_idx;
                    ts_d    = req_ts[arb_idx*TS_W +: TS_W];
                    ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (stale) begin
                    status_d = STS_STALE;
                    state_d  = S_REPORT;
                end
`ifdef AUTH_TOKEN_CACHE_EN
                else if (token_live[id_q]) begin
                    status_d = STS_CACHED;
                    state_d  = S_REPORT;
                end
`endif
                else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                wd_d    = WD_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    status_d = eng_ok ? STS_OK : STS_FAIL;
                    state_d  = S_REPORT;
                end else if (wd_q == WD_W'(ENG_TIMEOUT)) begin
                    status_d = STS_TIMEOUT;
                    state_d  = S_REPORT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Token lifetimes: count down each cycle; the completion outcome overrides.
    always_comb begin
        tok_d = tok_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tok_q[i] != '0) tok_d[i] = tok_q[i] - 1'b1;
            if (state_q == S_REPORT && id_q == IDX_W'(i)) begin
                if (status_q == STS_OK) begin
                    tok_d[i] = TOK_W'(T_VALID);
                end else if (status_q == STS_FAIL || status_q == STS_TIMEOUT) begin
                    tok_d[i] = '0;
                end
            end
        end
    end

    // Token-live flags straight from the counters.
    always_comb begin
        token_live = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            token_live[i] = (tok_q[i] != '0);
        end
    end

    // State registers; reset abandons any in-flight request silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            ptr_q    <= '0;
            ts_q     <= '0;
            now_q    <= '0;
            wd_q     <= '0;
            status_q <= STS_OK;
            tok_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            ts_q     <= ts_d;
            now_q    <= now_d;
            wd_q     <= wd_d;
            status_q <= status_d;
            tok_q    <= tok_d;
        end
    end

    assign req_ready   = arb_grant;
    assign now_ts      = now_q;
    assign eng_start   = (state_q == S_START);
    assign eng_id      = id_q;
    assign eng_abort   = (state_q == S_WAIT) && !eng_done && (wd_q == WD_W'(ENG_TIMEOUT));
    assign done_valid  = (state_q == S_REPORT);
    assign done_id     = done_valid ? id_q : '0;
    assign done_status = done_valid ? status_q : 3'd0;

endmodule

// File: tb/tb_auth_session_scheduler.sv
// tb_auth_session_scheduler: directed self-checking bench for
// auth_session_scheduler with default parameters (4 requesters).
module tb_auth_session_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [255:0] req_ts = '0;
    logic [3:0]   req_ready;
    logic [63:0]  now_ts;
    logic         eng_start;
    logic [1:0]   eng_id;
    logic         eng_abort;
    logic         eng_done = 1'b0;
    logic         eng_ok = 1'b0;
    logic         done_valid;
    logic [1:0]   done_id;
    logic [2:0]   done_status;
    logic [3:0]   token_live;

    int n_pass = 0;
    int n_total = 0;
    longint unsigned tb_now;

    auth_session_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ts      (req_ts),
        .req_ready   (req_ready),
        .now_ts      (now_ts),
        .eng_start   (eng_start),
        .eng_id      (eng_id),
        .eng_abort   (eng_abort),
        .eng_done    (eng_done),
        .eng_ok      (eng_ok),
        .done_valid  (done_valid),
        .done_id     (done_id),
        .done_status (done_status),
        .token_live  (token_live)
    );

    always #5 clk = ~clk;

    // Reference cycle count used to build request timestamps.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_now <= 0;
        else        tb_now <= tb_now + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request so its delta at the check cycle equals d; returns
    // req_ready seen in the accept cycle and in the cycle after.
    task automatic issue(input int id, input longint d, output logic [3:0] ra, output logic [3:0] rb);
        req_ts[id*64 +: 64] = tb_now + 64'd2 - 64'(d);
        req_valid[id] = 1'b1;
        tick();
        ra = req_ready;
        tick();
        rb = req_ready;
        req_valid[id] = 1'b0;
    endtask

    task automatic test_reset();
        n_total++; if (req_ready !== 4'b0) $display("FAIL rst_ready got %b want 0000", req_ready); else n_pass++;
        n_total++; if (now_ts !== 64'd0) $display("FAIL rst_now got %0d want 0", now_ts); else n_pass++;
        n_total++; if ({eng_start, eng_abort, done_valid} !== 3'b000) $display("FAIL rst_strobes got %b want 000", {eng_start, eng_abort, done_valid}); else n_pass++;
        n_total++; if ({eng_id, done_id, done_status, token_live} !== 11'd0) $display("FAIL rst_fields got %h want 0", {eng_id, done_id, done_status, token_live}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_total++; if (now_ts !== 64'd3) $display("FAIL now_count got %0d want 3", now_ts); else n_pass++;
    endtask

    task automatic test_round_robin();
        int waited;
        int exp_id;
        req_ts = {4{64'hFFFF_FFFF_FFFF_0000}};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % 4;
            waited = 0;
            do begin
                tick();
                waited++;
            end while (req_ready == 4'b0 && waited < 10);
            n_total++; if (req_ready !== (4'b0001 << exp_id)) $display("FAIL rr_grant%0d got %b want %b", g, req_ready, 4'b0001 << exp_id); else n_pass++;
            n_total++; if (waited !== ((g == 0) ? 1 : 2)) $display("FAIL rr_spacing%0d got %0d want %0d", g, waited, (g == 0) ? 1 : 2); else n_pass++;
            tick();
            n_total++; if (req_ready !== 4'b0) $display("FAIL rr_pulse%0d got %b want 0000", g, req_ready); else n_pass++;
            if (g == 4) req_valid = 4'b0;
            tick();
            n_total++; if ({done_valid, done_status, done_id, eng_start} !== {1'b1, 3'd2, 2'(exp_id), 1'b0})
                $display("FAIL rr_stale%0d got v%b s%0d id%0d st%b want v1 s2 id%0d st0", g, done_valid, done_status, done_id, eng_start, exp_id);
            else n_pass++;
        end
        tick(); tick();
    endtask

    task automatic test_engine_ok();
        logic [3:0] ra, rb;
        int live_bad;
        issue(0, 2, ra, rb);
        n_total++; if (ra !== 4'b0001) $display("FAIL ok_ready got %b want 0001", ra); else n_pass++;
        n_total++; if (rb !== 4'b0000) $display("FAIL ok_ready_pulse got %b want 0000", rb); else n_pass++;
        tick();
        n_total++; if ({eng_start, eng_id} !== {1'b1, 2'd0}) $display("FAIL ok_start got %b/%0d want 1/0", eng_start, eng_id); else n_pass++;
        tick(); tick(); tick();
        eng_done = 1'b1; eng_ok = 1'b1;
        tick();
        eng_done = 1'b0; eng_ok = 1'b0;
        n_total++; if ({done_valid, done_id, done_status} !== {1'b1, 2'd0, 3'd0}) $display("FAIL ok_done got v%b id%0d s%0d want v1 id0 s0", done_valid, done_id, done_status); else n_pass++;
        tick();
        n_total++; if ({done_valid, token_live} !== 5'b0_0001) $display("FAIL ok_token_load got %b want 00001", {done_valid, token_live}); else n_pass++;
        live_bad = 0;
        for (int k = 0; k < 59; k++) begin
            tick();
            if (token_live[0] !== 1'b1) live_bad++;
        end
        n_total++; if (live_bad !== 0) $display("FAIL ok_token_hold got %0d dead cycles want 0", live_bad); else n_pass++;
        tick();
        n_total++; if (token_live !== 4'b0) $display("FAIL ok_token_expire got %b want 0000", token_live); else n_pass++;
    endtask

    task automatic test_stale();
        logic [3:0] ra, rb;
        issue(2, 11, ra, rb);
        n_total++; if (ra !== 4'b0100) $display("FAIL st_ready got %b want 0100", ra); else n_pass++;
        tick();
        n_total++; if ({done_valid, done_status, done_id, eng_start} !== {1'b1, 3'd2, 2'd2, 1'b0})
            $display("FAIL st_old got v%b s%0d id%0d st%b want v1 s2 id2 st0", done_valid, done_status, done_id, eng_start);
        else n_pass++;
        tick();
        n_total++; if ({eng_start, done_valid} !== 2'b00) $display("FAIL st_after got %b want 00", {eng_start, done_valid}); else n_pass++;
        issue(1, -1, ra, rb);
        n_total++; if (eng_start !== 1'b0) $display("FAIL st_fut_start got %b want 0", eng_start); else n_pass++;
        tick();
        n_total++; if ({done_valid, done_status, done_id, eng_start} !== {1'b1, 3'd2, 2'd1, 1'b0})
            $display("FAIL st_future got v%b s%0d id%0d st%b want v1 s2 id1 st0", done_valid, done_status, done_id, eng_start);
        else n_pass++;
        tick();
    endtask

    task automatic test_fail_min_latency();
        logic [3:0] ra, rb;
        issue(2, 10, ra, rb);
        tick();
        n_total++; if ({eng_start, eng_id, done_valid} !== {1'b1, 2'd2, 1'b0}) $display("FAIL fl_start got %b want 1100", {eng_start, eng_id, done_valid}); else n_pass++;
        eng_done = 1'b1; eng_ok = 1'b0;
        tick();
        n_total++; if ({done_valid, eng_start} !== 2'b00) $display("FAIL fl_early got %b want 00", {done_valid, eng_start}); else n_pass++;
        tick();
        eng_done = 1'b0;
        n_total++; if ({done_valid, done_id, done_status} !== {1'b1, 2'd2, 3'd3}) $display("FAIL fl_done got v%b id%0d s%0d want v1 id2 s3", done_valid, done_id, done_status); else n_pass++;
        tick();
        n_total++; if ({done_valid, token_live} !== 5'b0) $display("FAIL fl_token got %b want 00000", {done_valid, token_live}); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [3:0] ra, rb;
        int k;
`ifndef AUTH_TOKEN_CACHE_EN
        issue(3, 2, ra, rb);
        tick();
        eng_done = 1'b1; eng_ok = 1'b1;
        tick(); tick();
        eng_done = 1'b0; eng_ok = 1'b0;
        tick();
        n_total++; if (token_live[3] !== 1'b1) $display("FAIL to_preload got %b want 1", token_live[3]); else n_pass++;
`endif
        issue(3, 2, ra, rb);
        tick();
        n_total++; if (eng_start !== 1'b1) $display("FAIL to_start got %b want 1", eng_start); else n_pass++;
        k = 0;
        do begin
            tick();
            k++;
        end while (eng_abort !== 1'b1 && k < 60);
        n_total++; if (k !== 32) $display("FAIL to_abort_cycle got %0d want 32", k); else n_pass++;
        n_total++; if (done_valid !== 1'b0) $display("FAIL to_abort_dv got %b want 0", done_valid); else n_pass++;
        tick();
        n_total++; if ({done_valid, done_id, done_status, eng_abort} !== {1'b1, 2'd3, 3'd4, 1'b0})
            $display("FAIL to_done got v%b id%0d s%0d ab%b want v1 id3 s4 ab0", done_valid, done_id, done_status, eng_abort);
        else n_pass++;
`ifndef AUTH_TOKEN_CACHE_EN
        n_total++; if (token_live[3] !== 1'b1) $display("FAIL to_token_before got %b want 1", token_live[3]); else n_pass++;
`endif
        tick();
        n_total++; if (token_live[3] !== 1'b0) $display("FAIL to_token_clear got %b want 0", token_live[3]); else n_pass++;
    endtask

    task automatic test_cache();
        logic [3:0] ra, rb;
        issue(2, 2, ra, rb);
        tick();
        eng_done = 1'b1; eng_ok = 1'b1;
        tick(); tick();
        eng_done = 1'b0; eng_ok = 1'b0;
        n_total++; if ({done_valid, done_status} !== {1'b1, 3'd0}) $display("FAIL ca_first got v%b s%0d want v1 s0", done_valid, done_status); else n_pass++;
        repeat (5) tick();
        n_total++; if (token_live[2] !== 1'b1) $display("FAIL ca_live got %b want 1", token_live[2]); else n_pass++;
        issue(2, 2, ra, rb);
        n_total++; if (ra !== 4'b0100) $display("FAIL ca_ready got %b want 0100", ra); else n_pass++;
        tick();
`ifdef AUTH_TOKEN_CACHE_EN
        n_total++; if ({done_valid, done_status, done_id, eng_start} !== {1'b1, 3'd1, 2'd2, 1'b0})
            $display("FAIL ca_cached got v%b s%0d id%0d st%b want v1 s1 id2 st0", done_valid, done_status, done_id, eng_start);
        else n_pass++;
        tick();
`else
        n_total++; if ({eng_start, done_valid} !== 2'b10) $display("FAIL ca_engine got %b want 10", {eng_start, done_valid}); else n_pass++;
        eng_done = 1'b1; eng_ok = 1'b1;
        tick(); tick();
        eng_done = 1'b0; eng_ok = 1'b0;
        n_total++; if ({done_valid, done_status, done_id} !== {1'b1, 3'd0, 2'd2}) $display("FAIL ca_second got v%b s%0d id%0d want v1 s0 id2", done_valid, done_status, done_id); else n_pass++;
        tick();
`endif
    endtask

    task automatic test_reset_midflight();
        logic [3:0] ra, rb;
        int bad;
        issue(1, 2, ra, rb);
        tick(); tick();
        n_total++; if (token_live !== 4'b0100) $display("FAIL rm_pre_token got %b want 0100", token_live); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if ({req_ready, eng_start, eng_abort, done_valid} !== 7'b0) $display("FAIL rm_strobes got %b want 0000000", {req_ready, eng_start, eng_abort, done_valid}); else n_pass++;
        n_total++; if ({now_ts, token_live, eng_id, done_id, done_status} !== 75'd0) $display("FAIL rm_fields got %h want 0", {now_ts, token_live, eng_id, done_id, done_status}); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        eng_done = 1'b1; eng_ok = 1'b1;
        tick();
        eng_done = 1'b0; eng_ok = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (done_valid !== 1'b0 || eng_start !== 1'b0) bad++;
            tick();
        end
        n_total++; if (bad !== 0) $display("FAIL rm_late_done got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    initial begin
        #12;
        test_reset();
        test_round_robin();
        test_engine_ok();
        test_stale();
        test_fail_min_latency();
        test_timeout();
        test_cache();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1);
    end

endmodule
